// File: rtl/booth_control.sv
// Sequencing FSM for a radix-2 Booth multiplier datapath: load, then N
// evaluate/shift iterations, then a one-cycle done pulse.
module booth_control #(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic          reloj,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    q_pair,
  output logic          load_regs,
  output logic          add_m,
  output logic          sub_m,
  output logic          shift,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] iter_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] iter_next;

  // State and iteration counter registers
  always_ff @(posedge reloj or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      iter_count <= '0;
    end else begin
      state      <= state_next;
      iter_count <= iter_next;
    end
  end

  // Next state; the counter saturates at zero so a stray SHIFT cannot wrap it
  always_comb begin
    state_next = state;
    iter_next  = iter_count;
    unique case (state)
      IDLE: begin
        iter_next = '0;
        if (start) state_next = LOAD;
      end
      LOAD: begin
        iter_next  = CW'(N);
        state_next = EVAL;
      end
      EVAL: state_next = SHIFT;
      SHIFT: begin
        if (iter_count != '0) iter_next = iter_count - CW'(1);
        if (iter_count <= CW'(1)) state_next = DONE;
        else                      state_next = EVAL;
      end
      DONE: begin
        iter_next  = '0;
        state_next = IDLE;
      end
      default: begin
        iter_next  = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Strobes decode from state only, plus q_pair while evaluating
  always_comb begin
    load_regs = 1'b0;
    add_m     = 1'b0;
    sub_m     = 1'b0;
    shift     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: ;
      LOAD: begin
        load_regs = 1'b1;
        busy      = 1'b1;
      end
      EVAL: begin
        busy  = 1'b1;
        add_m = (q_pair == 2'b01);
        sub_m = (q_pair == 2'b10);
      end
      SHIFT: begin
        shift = 1'b1;
        busy  = 1'b1;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_booth_control.sv
// Scoreboard bench for booth_control: two instances (N=8, N=4), each driving a
// behavioural Booth datapath; products are checked against signed multiplication.
module tb_booth_control;

  localparam int unsigned N8  = 8;
  localparam int unsigned N4  = 4;
  localparam int unsigned CW8 = 4;
  localparam int unsigned CW4 = 3;

  logic reloj = 1'b0;
  logic reset;
  logic start8, start4;
  logic [1:0] qp8, qp4;
  logic load8, add8, sub8, sh8, busy8, done8;
  logic load4, add4, sub4, sh4, busy4, done4;
  logic [CW8-1:0] iter8;
  logic [CW4-1:0] iter4;

  always #5 reloj = ~reloj;

  booth_control #(.N(N8), .CW(CW8)) u_dut8 (
    .reloj(reloj), .reset(reset), .start(start8), .q_pair(qp8),
    .load_regs(load8), .add_m(add8), .sub_m(sub8), .shift(sh8),
    .busy(busy8), .done(done8), .iter_count(iter8));

  booth_control #(.N(N4), .CW(CW4)) u_dut4 (
    .reloj(reloj), .reset(reset), .start(start4), .q_pair(qp4),
    .load_regs(load4), .add_m(add4), .sub_m(sub4), .shift(sh4),
    .busy(busy4), .done(done4), .iter_count(iter4));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge reloj) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp_v, cyc);
    end
  endtask

  typedef struct {
    logic [15:0] prod;
    logic        chk;
    int          t0;
  } exp_t;
  exp_t sb8[$];
  exp_t sb4[$];
  int starts8 = 0, starts4 = 0;

  // Behavioural datapath, N=8; A carries a guard bit so M=-2^(N-1) is exact
  logic [8:0] a8;
  logic [7:0] q8, m8, op_m8, op_q8;
  logic       qm8;
  logic       frc_en;
  logic [1:0] frc_tab [0:3];
  int         frc_idx;
  assign qp8 = frc_en ? frc_tab[frc_idx % 4] : {q8[0], qm8};

  always @(posedge reloj or posedge reset)
    if (reset) begin
      a8 <= '0; q8 <= '0; qm8 <= 1'b0; m8 <= '0;
    end else if (load8) begin
      a8 <= '0; q8 <= op_q8; qm8 <= 1'b0; m8 <= op_m8;
    end else if (add8) a8 <= a8 + {m8[7], m8};
    else if (sub8) a8 <= a8 - {m8[7], m8};
    else if (sh8) {a8, q8, qm8} <= {a8[8], a8, q8};

  always @(posedge reloj)
    if (load8) frc_idx <= 0;
    else if (sh8) frc_idx <= frc_idx + 1;

  // Behavioural datapath, N=4
  logic [4:0] a4;
  logic [3:0] q4, m4, op_m4, op_q4;
  logic       qm4;
  assign qp4 = {q4[0], qm4};

  always @(posedge reloj or posedge reset)
    if (reset) begin
      a4 <= '0; q4 <= '0; qm4 <= 1'b0; m4 <= '0;
    end else if (load4) begin
      a4 <= '0; q4 <= op_q4; qm4 <= 1'b0; m4 <= op_m4;
    end else if (add4) a4 <= a4 + {m4[3], m4};
    else if (sub4) a4 <= a4 - {m4[3], m4};
    else if (sh4) {a4, q4, qm4} <= {a4[4], a4, q4};

  // Monitor N=8: per-operation bookkeeping, compare on done
  int shifts8, evals8, adds8, subs8, seq_err8, strb_err8, exp_iter8;
  int loads8 = 0;
  exp_t e8;
  always @(negedge reloj) if (!reset) begin
    if (load8) begin
      shifts8 = 0; evals8 = 0; adds8 = 0; subs8 = 0;
      seq_err8 = 0; strb_err8 = 0; exp_iter8 = N8; loads8++;
    end
    if (add8 && sub8) strb_err8++;
    if ((add8 || sub8) && (!busy8 || sh8 || load8)) strb_err8++;
    if ((sh8 || load8) && !busy8) strb_err8++;
    if (done8 && (busy8 || sh8 || load8 || add8 || sub8)) strb_err8++;
    if (busy8 && !load8 && !sh8) begin
      evals8++;
      if (add8) adds8++;
      if (sub8) subs8++;
      if (add8 != (qp8 == 2'b01) || sub8 != (qp8 == 2'b10)) strb_err8++;
      if (iter8 != 4'(exp_iter8)) seq_err8++;
    end
    if (sh8) begin
      if (iter8 != 4'(exp_iter8)) seq_err8++;
      exp_iter8--;
      shifts8++;
    end
    if (done8) begin
      if (sb8.size() == 0) check("unexpected_done8", 32'd1, 32'd0);
      else begin
        e8 = sb8.pop_front();
        check("latency8", 32'(cyc - e8.t0), 32'(2 * N8 + 1));
        check("shifts8", 32'(shifts8), 32'(N8));
        check("evals8", 32'(evals8), 32'(N8));
        check("iter_seq8", 32'(seq_err8), 32'd0);
        check("strobes8", 32'(strb_err8), 32'd0);
        check("iter_end8", 32'(iter8), 32'd0);
        if (e8.chk) check("product8", 32'({a8[7:0], q8}), 32'(e8.prod));
      end
    end
  end

  // Monitor N=4
  int shifts4, err4, exp_iter4;
  int loads4 = 0;
  exp_t e4;
  always @(negedge reloj) if (!reset) begin
    if (load4) begin
      shifts4 = 0; err4 = 0; exp_iter4 = N4; loads4++;
    end
    if (busy4 && !load4 && !sh4) begin
      if (iter4 != 3'(exp_iter4)) err4++;
      if (add4 != (qp4 == 2'b01) || sub4 != (qp4 == 2'b10)) err4++;
    end
    if (sh4) begin
      if (iter4 != 3'(exp_iter4) || add4 || sub4) err4++;
      exp_iter4--;
      shifts4++;
    end
    if (done4) begin
      if (sb4.size() == 0) check("unexpected_done4", 32'd1, 32'd0);
      else begin
        e4 = sb4.pop_front();
        check("latency4", 32'(cyc - e4.t0), 32'(2 * N4 + 1));
        check("shifts4", 32'(shifts4), 32'(N4));
        check("seq4", 32'(err4), 32'd0);
        check("product4", 32'({a4[3:0], q4}), 32'(e4.prod[7:0]));
      end
    end
  end

  function automatic logic [15:0] mul8(input logic [7:0] m, input logic [7:0] q);
    int p;
    p = int'($signed(m)) * int'($signed(q));
    return 16'(p);
  endfunction

  function automatic logic [15:0] mul4(input logic [3:0] m, input logic [3:0] q);
    int p;
    p = int'($signed(m)) * int'($signed(q));
    return 16'(8'(p));
  endfunction

  task automatic wait8();
    int n = 0;
    while (sb8.size() != 0 && n < 200) begin
      @(negedge reloj); #1; n++;
    end
    if (sb8.size() != 0) begin
      check("timeout8", 32'd1, 32'd0);
      sb8.delete();
    end
  endtask

  task automatic wait4();
    int n = 0;
    while (sb4.size() != 0 && n < 200) begin
      @(negedge reloj); #1; n++;
    end
    if (sb4.size() != 0) begin
      check("timeout4", 32'd1, 32'd0);
      sb4.delete();
    end
  endtask

  // Issue one start pulse; the start edge is timestamped for the latency check
  task automatic launch8(input logic [7:0] m, input logic [7:0] q, input logic chk);
    op_m8 = m; op_q8 = q;
    @(negedge reloj); start8 = 1'b1;
    @(posedge reloj); #1;
    sb8.push_back('{prod: mul8(m, q), chk: chk, t0: cyc});
    starts8++;
    @(negedge reloj); start8 = 1'b0;
  endtask

  task automatic run8(input logic [7:0] m, input logic [7:0] q, input logic chk);
    launch8(m, q, chk);
    wait8();
  endtask

  task automatic run4(input logic [3:0] m, input logic [3:0] q);
    op_m4 = m; op_q4 = q;
    @(negedge reloj); start4 = 1'b1;
    @(posedge reloj); #1;
    sb4.push_back('{prod: mul4(m, q), chk: 1'b1, t0: cyc});
    starts4++;
    @(negedge reloj); start4 = 1'b0;
    wait4();
  endtask

  task automatic reset_mid_op();
    int evc = 0;
    int n = 0;
    launch8(8'h21, 8'h5A, 1'b0);
    while (evc < 3 && n < 50) begin
      @(negedge reloj); #1; n++;
      if (busy8 && !load8 && !sh8) evc++;
    end
    check("reach_eval3", 32'(evc), 32'd3);
    #1 reset = 1'b1;
    #1;
    check("rst_async_out", 32'({load8, add8, sub8, sh8, busy8, done8}), 32'd0);
    check("rst_async_iter", 32'(iter8), 32'd0);
    sb8.delete();
    @(posedge reloj); #1;
    check("rst_held_out", 32'({load8, add8, sub8, sh8, busy8, done8}), 32'd0);
    @(negedge reloj) reset = 1'b0;
    repeat (3) @(negedge reloj);
    #1 check("rst_release_idle", 32'({load8, busy8, done8, iter8}), 32'd0);
  endtask

  task automatic busy_starts();
    launch8(8'h0B, 8'hF3, 1'b1);
    repeat (3) @(negedge reloj);
    start8 = 1'b1;
    @(negedge reloj) start8 = 1'b0;
    repeat (5) @(negedge reloj);
    start8 = 1'b1;
    @(negedge reloj) start8 = 1'b0;
    wait8();
    repeat (25) @(negedge reloj);
    #1 check("busy_start_ignored", 32'(loads8), 32'(starts8));
  endtask

  // start held high across DONE relaunches right after the return to IDLE
  task automatic held_start();
    int k;
    op_m8 = 8'h13; op_q8 = 8'hE7;
    @(negedge reloj); start8 = 1'b1;
    @(posedge reloj); #1;
    sb8.push_back('{prod: mul8(8'h13, 8'hE7), chk: 1'b1, t0: cyc});
    starts8++;
    k = cyc;
    @(posedge reloj); #1;
    op_m8 = 8'hC4; op_q8 = 8'h29;
    repeat (2 * N8 + 2) @(posedge reloj);
    #1;
    check("held_start_edge", 32'(cyc - k), 32'(2 * N8 + 3));
    sb8.push_back('{prod: mul8(8'hC4, 8'h29), chk: 1'b1, t0: cyc});
    starts8++;
    @(negedge reloj); #1;
    check("held_relaunch_load", 32'(load8), 32'd1);
    start8 = 1'b0;
    wait8();
  endtask

  initial begin
    frc_tab[0] = 2'b01; frc_tab[1] = 2'b10; frc_tab[2] = 2'b00; frc_tab[3] = 2'b11;
    reset = 1'b1; start8 = 1'b0; start4 = 1'b0; frc_en = 1'b0;
    op_m8 = '0; op_q8 = '0; op_m4 = '0; op_q4 = '0;
    repeat (2) @(negedge reloj);
    #1;
    check("reset_out8", 32'({load8, add8, sub8, sh8, busy8, done8}), 32'd0);
    check("reset_iter8", 32'(iter8), 32'd0);
    check("reset_out4", 32'({load4, add4, sub4, sh4, busy4, done4, iter4}), 32'd0);
    @(negedge reloj) reset = 1'b0;

    run8(8'h03, 8'hFE, 1'b1);
    run8(8'h80, 8'h80, 1'b1);
    run8(8'h7F, 8'h80, 1'b1);

    reset_mid_op();
    run8(8'h05, 8'h07, 1'b1);

    frc_en = 1'b1;
    run8(8'h55, 8'h33, 1'b0);
    frc_en = 1'b0;
    check("forced_adds", 32'(adds8), 32'd2);
    check("forced_subs", 32'(subs8), 32'd2);

    busy_starts();
    held_start();

    for (int i = 0; i < 30; i++)
      run8(8'($urandom), 8'($urandom), 1'b1);

    run4(4'hD, 4'h5);
    check("n4_product_f1", 32'({a4[3:0], q4}), 32'h0000_00F1);
    for (int i = 0; i < 15; i++)
      run4(4'($urandom), 4'($urandom));

    repeat (30) @(negedge reloj);
    #1;
    check("load_count8", 32'(loads8), 32'(starts8));
    check("load_count4", 32'(loads4), 32'(starts4));
    check("final_idle8", 32'({busy8, done8, iter8}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
